// File: rtl/fifo_rd_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared definitions for the FIFO read-side stream adapter:
//   - occupancy encoding of the two-entry skid buffer (EMPTY / ONE / TWO)
//   - RD_LAT    : FIFO read latency in cycles (data valid the cycle after pop)
//   - BUF_DEPTH : number of words the skid buffer can hold
//   - pending_words() : words held plus in flight, net of this cycle's pop
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

  localparam int RD_LAT    = 1;
  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_TWO   = 2'd2;

  // Words that will still be owned by the adapter after this cycle's pop.
  // pop implies occ >= 1, so the subtraction never underflows.
  function automatic logic [2:0] pending_words(input occ_t occ,
                                               input logic infl,
                                               input logic pop);
    return {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry buffer that absorbs the FIFO read latency. Words arrive on
// wr_en/wr_data (the cycle after the FIFO pop) and leave from the head
// register when pop is asserted.
// Ports:
//   rd_clk, rd_rst : clock, asynchronous active-high reset
//   wr_en, wr_data : capture a word at the tail
//   pop            : head word is consumed this cycle
//   occ            : number of buffered words (OCC_EMPTY/ONE/TWO)
//   valid          : head register holds a word
//   head           : head word, straight from a register
// -----------------------------------------------------------------------------
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output occ_t              occ,
  output logic              valid,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] tail;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the data registers are reset as well as the control state, so
  // m_data reads 0 out of reset instead of whatever was left behind.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      occ  <= OCC_EMPTY;
      head <= '0;
      tail <= '0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (wr_en) begin
            head <= wr_data;
            occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (wr_en && pop) begin
            // Head leaves as the new word lands: the new word becomes head.
            head <= wr_data;
          end else if (wr_en) begin
            tail <= wr_data;
            occ  <= OCC_TWO;
          end else if (pop) begin
            occ <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // The issue logic never lets a capture land here.
          if (pop) begin
            head <= tail;
            occ  <= OCC_ONE;
          end
        end
        default: occ <= OCC_EMPTY;
      endcase
    end
  end

  assign valid = (occ != OCC_EMPTY);

  // The issue rule caps held + in-flight words at BUF_DEPTH.
  a_no_capture_when_full : assert property (
    @(posedge rd_clk) disable iff (rd_rst) !(wr_en && occ == OCC_TWO)
  );

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side consumer for the dual-clock FIFO (rd_clk domain). Issues FIFO
// pops, absorbs the one-cycle read latency in a two-entry skid buffer and
// presents a full-throughput valid/ready stream framed into PKT_LEN-beat
// packets, with beat and packet counters.
// Ports:
//   rd_clk, rd_rst       : clock, asynchronous active-high reset
//   fifo_empty           : FIFO empty flag
//   fifo_rd_en           : FIFO pop request (combinational)
//   fifo_rd_data         : FIFO data, valid the cycle after fifo_rd_en
//   m_valid/m_ready      : stream handshake
//   m_data, m_last       : stream payload and end-of-packet marker
//   word_cnt, pkt_cnt    : accepted beats / completed packets, wrapping
// -----------------------------------------------------------------------------
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PKT_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  pkt_cnt
);

  localparam int                BEAT_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(PKT_LEN - 1);

  occ_t              occ;
  logic              infl;      // a FIFO read issued last cycle (RD_LAT = 1)
  logic              pop;
  logic [2:0]        pending;
  logic [BEAT_W-1:0] beat_idx;

  assign pop = m_valid && m_ready;

  // Issue only while the words we will still own after this cycle leave
  // room for one more; this is what makes a buffer overflow impossible.
  // NOTE: every signal driven here is assigned on every path, so no latch.
  always_comb begin
    pending    = pending_words(occ, infl, pop);
    fifo_rd_en = !fifo_empty && (pending < 3'(BUF_DEPTH));
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      infl <= 1'b0;
    end else begin
      infl <= fifo_rd_en;
    end
  end

  fifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .rd_clk  (rd_clk),
    .rd_rst  (rd_rst),
    .wr_en   (infl),
    .wr_data (fifo_rd_data),
    .pop     (pop),
    .occ     (occ),
    .valid   (m_valid),
    .head    (m_data)
  );

  // Framing and statistics: all advance only on an accepted beat.
  assign m_last = m_valid && (beat_idx == LAST_IDX);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      beat_idx <= '0;
      word_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (pop) begin
      word_cnt <= word_cnt + CNT_W'(1);
      if (m_last) begin
        beat_idx <= '0;
        pkt_cnt  <= pkt_cnt + CNT_W'(1);
      end else begin
        beat_idx <= beat_idx + BEAT_W'(1);
      end
    end
  end

endmodule
